// File: rtl/bal_seq.sv
// -----------------------------------------------------------------------------
// bal_seq -- power-up / soft-start sequencer for the balance controller.
//
// Walks the platform through OFF -> WAIT_RIDER -> RAMP -> RUN. Sequencing
// advances only on the one-cycle vld sample strobe. While ramping, ss_tmr
// climbs one step per vld until it saturates at 8'hFF, at which point the
// block is in RUN. An optional overspeed monitor latches a fault state.
//
// Optional feature macro: BAL_SEQ_OVRSPD_EN
//   defined   -> four consecutive too_fast samples in RAMP/RUN enter OVERSPD
//   undefined -> too_fast ignored, OVERSPD unreachable, ovr_spd_flt tied to 0
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   pwr_up       in   rider power-up request (0 forces OFF)
//   rider_off    in   rider not on platform
//   vld          in   new inertial sample strobe
//   too_fast     in   overspeed indication from balance_cntrl
//   en_steer_req in   steering enable request
//   ss_tmr       out  [7:0] soft-start scale factor
//   pid_en       out  enables PID update
//   clr_integ    out  holds PID integrator at zero
//   en_steer     out  gated steering enable
//   ovr_spd_flt  out  latched overspeed fault
//   seq_state    out  [2:0] OFF=0 WAIT_RIDER=1 RAMP=2 RUN=3 OVERSPD=4
// -----------------------------------------------------------------------------
module bal_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_up,
    input  logic       rider_off,
    input  logic       vld,
    input  logic       too_fast,
    input  logic       en_steer_req,
    output logic [7:0] ss_tmr,
    output logic       pid_en,
    output logic       clr_integ,
    output logic       en_steer,
    output logic       ovr_spd_flt,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_OFF        = 3'd0,
        S_WAIT_RIDER = 3'd1,
        S_RAMP       = 3'd2,
        S_RUN        = 3'd3,
        S_OVERSPD    = 3'd4
    } state_t;

    localparam logic [7:0] SS_MAX = 8'hFF;

    state_t     state;
    state_t     nxt_state;
    logic [7:0] nxt_ss;

`ifdef BAL_SEQ_OVRSPD_EN
    logic [2:0] ovr_cnt;
    logic [2:0] nxt_ovr_cnt;
    logic       ovr_trip;
`else
    // too_fast has no consumer in this build.
    logic unused_too_fast;
    assign unused_too_fast = too_fast;
`endif

    // Next-state logic. Outputs are then registered from nxt_state so that a
    // transition sampled at an edge is reflected on every output right after it.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        nxt_state = state;
        nxt_ss    = ss_tmr;
`ifdef BAL_SEQ_OVRSPD_EN
        nxt_ovr_cnt = ovr_cnt;
        ovr_trip    = 1'b0;
        // Consecutive-overspeed counter; any clean sample breaks the run.
        if (vld && (state == S_RAMP || state == S_RUN)) begin
            if (too_fast) begin
                nxt_ovr_cnt = 3'(ovr_cnt + 3'd1);
                ovr_trip    = (ovr_cnt == 3'd3);
            end else begin
                nxt_ovr_cnt = 3'd0;
            end
        end
`endif

        // Priority: power-down, overspeed, rider-off, vld advance.
        if (!pwr_up) begin
            nxt_state = S_OFF;
            nxt_ss    = 8'd0;
`ifdef BAL_SEQ_OVRSPD_EN
            nxt_ovr_cnt = 3'd0;
        end else if (ovr_trip) begin
            // ss_tmr freezes at its value on entry.
            nxt_state = S_OVERSPD;
`endif
        end else begin
            case (state)
                S_OFF: begin
                    nxt_state = S_WAIT_RIDER;
                    nxt_ss    = 8'd0;
                end
                S_WAIT_RIDER: begin
                    nxt_ss = 8'd0;
                    // The sample that starts the ramp is also its first step.
                    if (vld && !rider_off) begin
                        nxt_state = S_RAMP;
                        nxt_ss    = 8'd1;
                    end
                end
                S_RAMP: begin
                    if (rider_off) begin
                        nxt_state = S_WAIT_RIDER;
                        nxt_ss    = 8'd0;
                    end else if (vld) begin
                        nxt_ss = 8'(ss_tmr + 8'd1);
                        if (ss_tmr == SS_MAX - 8'd1)
                            nxt_state = S_RUN;
                    end
                end
                S_RUN: begin
                    if (rider_off) begin
                        nxt_state = S_WAIT_RIDER;
                        nxt_ss    = 8'd0;
                    end else begin
                        nxt_ss = SS_MAX;
                    end
                end
                S_OVERSPD: begin
                    if (rider_off) begin
                        nxt_state = S_WAIT_RIDER;
                        nxt_ss    = 8'd0;
                    end
                end
                default: begin
                    // Unused encodings recover to OFF.
                    nxt_state = S_OFF;
                    nxt_ss    = 8'd0;
                end
            endcase
`ifdef BAL_SEQ_OVRSPD_EN
            if (nxt_state == S_WAIT_RIDER || nxt_state == S_OFF)
                nxt_ovr_cnt = 3'd0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_OFF;
            ss_tmr    <= 8'd0;
            pid_en    <= 1'b0;
            clr_integ <= 1'b1;
            en_steer  <= 1'b0;
        end else begin
            state     <= nxt_state;
            ss_tmr    <= nxt_ss;
            pid_en    <= (nxt_state == S_RAMP) || (nxt_state == S_RUN) ||
                         (nxt_state == S_OVERSPD);
            clr_integ <= !((nxt_state == S_RAMP) || (nxt_state == S_RUN) ||
                           (nxt_state == S_OVERSPD));
            en_steer  <= (nxt_state == S_RUN) && en_steer_req;
        end
    end

`ifdef BAL_SEQ_OVRSPD_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_cnt     <= 3'd0;
            ovr_spd_flt <= 1'b0;
        end else begin
            ovr_cnt     <= nxt_ovr_cnt;
            ovr_spd_flt <= (nxt_state == S_OVERSPD);
        end
    end
`else
    assign ovr_spd_flt = 1'b0;
`endif

    assign seq_state = state;

endmodule

// File: doc/bal_seq.md
BAL_SEQ -- requirements
Module: bal_seq

Interface
REQ-001 SHALL: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL: pwr_up  input  1  rider power-up request; 0 forces OFF.
REQ-004 SHALL: rider_off  input  1  rider not on platform.
REQ-005 SHALL: vld  input  1  one-cycle pulse marking a new inertial sample; sequencing advances only on vld.
REQ-006 SHALL: too_fast  input  1  overspeed indication from balance_cntrl.
REQ-007 SHALL: en_steer_req  input  1  steering enable request.
REQ-008 SHALL: ss_tmr  output  8  soft-start scale factor to balance_cntrl.
REQ-009 SHALL: pid_en  output  1  enables the balance_cntrl PID update.
REQ-010 SHALL: clr_integ  output  1  holds the PID integrator at zero.
REQ-011 SHALL: en_steer  output  1  gated steering enable to balance_cntrl.
REQ-012 SHALL: ovr_spd_flt  output  1  latched overspeed fault.
REQ-013 SHALL: seq_state  output  3  current state: OFF=0, WAIT_RIDER=1, RAMP=2, RUN=3, OVERSPD=4.

Function
REQ-014 SHALL: All outputs are registered; each output is a function of the registered state and ss_tmr, so a transition sampled at edge N is visible after edge N.
REQ-015 SHALL: Transition priority, highest first: pwr_up=0, overspeed, rider_off=1, vld advance.
REQ-016 SHALL: pwr_up=0 in any state -> OFF on the next edge; ss_tmr=0, the overspeed counter is cleared, and ovr_spd_flt=0.
REQ-017 SHALL: OFF -- pid_en=0, clr_integ=1, en_steer=0, ss_tmr=0; pwr_up=1 -> WAIT_RIDER.
REQ-018 SHALL: WAIT_RIDER -- pid_en=0, clr_integ=1, ss_tmr=0; vld=1 with rider_off=0 -> RAMP; rider_off=0 without vld has no effect.
REQ-019 SHALL: RAMP -- pid_en=1, clr_integ=0, en_steer=0.
REQ-020 SHALL: In RAMP, ss_tmr increments by 1 on each vld.
REQ-021 SHALL: In RAMP, the vld that increments ss_tmr from 8'hFE to 8'hFF also moves the block to RUN on the same edge.
REQ-022 SHALL: RUN -- ss_tmr=8'hFF held, pid_en=1, clr_integ=0, en_steer=en_steer_req registered.
REQ-023 SHALL: In RAMP or RUN, rider_off=1 -> WAIT_RIDER on the next edge; ss_tmr=0 and the overspeed counter is cleared.
REQ-024 SHALL: ss_tmr never wraps; it saturates at 8'hFF and is only cleared by OFF or WAIT_RIDER entry.
REQ-025 SHALL: OVERSPD -- pid_en=1, clr_integ=0, en_steer=0, ovr_spd_flt=1, ss_tmr held at its entry value.
REQ-026 SHALL: OVERSPD exits only via pwr_up=0 (-> OFF) or rider_off=1 (-> WAIT_RIDER, ovr_spd_flt cleared).
REQ-027 SHALL: Undefined seq_state encodings (5-7) -> OFF on the next edge.

Reset
REQ-028 SHALL: rst_n=0 at a rising edge -> seq_state=OFF, ss_tmr=0, pid_en=0, clr_integ=1, en_steer=0, ovr_spd_flt=0, overspeed counter=0.
REQ-029 SHALL: Reset asserted mid-RAMP or mid-RUN takes effect at the first edge with rst_n=0, with no partial ramp retained.
REQ-030 SHALL: After rst_n returns to 1, the first transition out of OFF requires pwr_up=1 sampled at a later edge.

Configuration
REQ-031 SHALL: Macro BAL_SEQ_OVRSPD_EN defined -> a 3-bit counter counts consecutive vld samples with too_fast=1 in RAMP or RUN.
REQ-032 SHALL: With BAL_SEQ_OVRSPD_EN, any vld with too_fast=0 clears the counter, and the 4th consecutive count -> OVERSPD on that edge.
REQ-033 SHALL: Macro BAL_SEQ_OVRSPD_EN undefined -> too_fast is ignored, OVERSPD is unreachable, and ovr_spd_flt is constant 0.

Verification
REQ-034 SHALL: rst_n=0 for 2 cycles, pwr_up=1 -> seq_state=0, clr_integ=1, ss_tmr=0; after release, seq_state=1 one edge later.
REQ-035 SHALL: pwr_up=1, rider_off=0, vld every 4th cycle -> RAMP after the 1st vld, ss_tmr=8'h01; after 255 vlds ss_tmr=8'hFF and seq_state=3 on the same edge.
REQ-036 SHALL: In RUN, en_steer_req=1 -> en_steer=1 one edge later; rider_off=1 -> seq_state=1, ss_tmr=0, en_steer=0, clr_integ=1 on the next edge.
REQ-037 SHALL: In RAMP with ss_tmr=8'h40, pwr_up=0 and rider_off=1 in the same cycle -> seq_state=0, ss_tmr=0 (pwr_up wins).
REQ-038 SHALL: With BAL_SEQ_OVRSPD_EN in RUN, too_fast=1 on 3 vlds, then too_fast=0 on 1 vld, then too_fast=1 on 4 vlds -> OVERSPD only after the last of those 4 vlds; ovr_spd_flt=1, en_steer=0, ss_tmr=8'hFF held; rider_off=1 -> seq_state=1, ovr_spd_flt=0.
REQ-039 SHALL: With BAL_SEQ_OVRSPD_EN undefined, too_fast=1 on 10 consecutive vlds in RUN -> seq_state stays 3 and ovr_spd_flt=0.
